regfile_scoreboard: RTL and testbench

Register file with an integrated per-register scoreboard for the pipelined CPU. The decode stage reads operands and ready flags from it, and issue reserves destination registers in it. The write-back stage writes results and releases those reservations. Storage is flops; read-port selection is 32:1 by register number.

---
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
//==============================================================================
// Module      : regfile_scoreboard
// Description : Flop-based register file with a per-register pending
//               scoreboard, write-through read bypass and reservation counter.
// Revision    : 1.0 - initial release
//==============================================================================
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 5
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic [ADDRBITS-1:0] ReadRegister1,
    input  logic [ADDRBITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]    ReadData1,
    output logic [WIDTH-1:0]    ReadData2,
    output logic                Ready1,
    output logic                Ready2,
    input  logic                IssueEnable,
    input  logic [ADDRBITS-1:0] IssueRegister,
    output logic                IssueAccept,
    input  logic                WriteEnable,
    input  logic [ADDRBITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]    WriteData,
    output logic [ADDRBITS:0]   PendingCount,
    output logic                Busy
);

    localparam int c_depth = 2 ** ADDRBITS;

    logic [WIDTH-1:0]    r_regs [c_depth];
    logic [c_depth-1:0]  r_pending;
    logic [ADDRBITS:0]   r_count;
    logic                r_busy;

    logic                w_wr_hit1;
    logic                w_wr_hit2;
    logic                w_wr_hit_issue;
    logic                w_accept;
    logic [c_depth-1:0]  w_pending_next;
    logic [ADDRBITS:0]   w_count_next;

    // A same-cycle write-back both forwards its data and satisfies readiness.
    assign w_wr_hit1      = WriteEnable && (WriteRegister == ReadRegister1);
    assign w_wr_hit2      = WriteEnable && (WriteRegister == ReadRegister2);
    assign w_wr_hit_issue = WriteEnable && (WriteRegister == IssueRegister);

    assign ReadData1 = (ReadRegister1 == '0) ? '0 :
                       w_wr_hit1             ? WriteData : r_regs[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == '0) ? '0 :
                       w_wr_hit2             ? WriteData : r_regs[ReadRegister2];

    assign Ready1 = (ReadRegister1 == '0) || !r_pending[ReadRegister1] || w_wr_hit1;
    assign Ready2 = (ReadRegister2 == '0) || !r_pending[ReadRegister2] || w_wr_hit2;

    assign w_accept = IssueEnable &&
                      ((IssueRegister == '0) || !r_pending[IssueRegister] || w_wr_hit_issue);
    assign IssueAccept = w_accept;

    // Set after clear so a new reservation outlives a same-edge write-back.
    always_comb begin
        w_pending_next = r_pending;
        if (WriteEnable) begin
            w_pending_next[WriteRegister] = 1'b0;
        end
        if (w_accept) begin
            w_pending_next[IssueRegister] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 1; i < c_depth; i++) begin
            w_count_next = w_count_next + (ADDRBITS + 1)'(w_pending_next[i]);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (WriteEnable && (WriteRegister != '0)) begin
                r_regs[WriteRegister] <= WriteData;
            end
            r_pending <= w_pending_next;
            r_count   <= w_count_next;
            r_busy    <= (w_count_next != '0);
        end
    end

    assign PendingCount = r_count;
    assign Busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
//==============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard against an
//               array-based architectural model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_regfile_scoreboard;

    logic        Clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadRegister1, ReadRegister2, IssueRegister, WriteRegister;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        Ready1, Ready2, IssueEnable, IssueAccept, WriteEnable, Busy;
    logic [5:0]  PendingCount;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_scoreboard dut (
        .Clk(Clk), .reset(reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Ready1(Ready1), .Ready2(Ready2),
        .IssueEnable(IssueEnable), .IssueRegister(IssueRegister),
        .IssueAccept(IssueAccept),
        .WriteEnable(WriteEnable), .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .PendingCount(PendingCount), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (WriteEnable && WriteRegister == a) return WriteData;
        return m_regs[a];
    endfunction

    function automatic logic m_ready(input logic [4:0] a);
        return (a == 0) || !m_pend[a] || (WriteEnable && WriteRegister == a);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ir,
                         input logic [4:0] r1, input logic [4:0] r2);
        WriteEnable = we; WriteRegister = wr; WriteData = wd;
        IssueEnable = ie; IssueRegister = ir;
        ReadRegister1 = r1; ReadRegister2 = r2;
    endtask

    // One clock: check combinational outputs, take the edge, update model,
    // then check the registered outputs.
    task automatic cycle(input string tag);
        logic acc;
        #1;
        acc = IssueEnable && m_ready(IssueRegister);
        chk({tag, "_rd1"}, ReadData1, m_read(ReadRegister1));
        chk({tag, "_rd2"}, ReadData2, m_read(ReadRegister2));
        chk({tag, "_rdy1"}, 32'(Ready1), 32'(m_ready(ReadRegister1)));
        chk({tag, "_rdy2"}, 32'(Ready2), 32'(m_ready(ReadRegister2)));
        chk({tag, "_acc"}, 32'(IssueAccept), 32'(acc));
        @(posedge Clk);
        if (WriteEnable && WriteRegister != 0) m_regs[WriteRegister] = WriteData;
        if (WriteEnable) m_pend[WriteRegister] = 1'b0;
        if (acc && IssueRegister != 0) m_pend[IssueRegister] = 1'b1;
        #1;
        chk({tag, "_cnt"}, 32'(PendingCount), 32'(m_count()));
        chk({tag, "_busy"}, 32'(Busy), 32'(m_count() != 0));
        @(negedge Clk);
    endtask

    initial begin
        m_clear();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        chk("rst_cnt", 32'(PendingCount), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        reset = 1'b0;

        // Reset state on every register, both ports
        for (int r = 0; r < 32; r++) begin
            drive(0, 0, 0, 0, 0, 5'(r), 5'(31 - r));
            cycle("init");
        end

        // Write then read, then same-cycle bypass
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle("wr5");
        drive(0, 0, 0, 0, 0, 5, 5);
        #1 chk("r5_read", ReadData1, 32'hDEADBEEF);
        cycle("rd5");
        drive(1, 5, 32'h12345678, 0, 0, 5, 0);
        #1 chk("r5_bypass", ReadData1, 32'h12345678);
        cycle("byp5");

        // Register 0 is hard-wired
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        cycle("wr0");
        drive(0, 0, 0, 1, 0, 0, 0);
        #1 chk("r0_acc", 32'(IssueAccept), 32'd1);
        chk("r0_read", ReadData1, 32'h0);
        cycle("iss0");
        chk("r0_cnt", 32'(PendingCount), 32'd0);

        // Reserve r7, WAW refusal, write-back release
        drive(0, 0, 0, 1, 7, 7, 0);
        cycle("iss7");
        chk("r7_cnt", 32'(PendingCount), 32'd1);
        drive(0, 0, 0, 1, 7, 7, 0);
        #1 chk("r7_waw", 32'(IssueAccept), 32'd0);
        chk("r7_rdy", 32'(Ready1), 32'd0);
        cycle("waw7");
        drive(1, 7, 32'hA5, 0, 0, 7, 0);
        #1 chk("r7_wb_rdy", 32'(Ready1), 32'd1);
        chk("r7_wb_data", ReadData1, 32'hA5);
        cycle("wb7");
        chk("r7_cnt0", 32'(PendingCount), 32'd0);

        // Same-edge write-back and re-issue of r9
        drive(0, 0, 0, 1, 9, 0, 0);
        cycle("iss9");
        drive(1, 9, 32'h11, 1, 9, 9, 0);
        #1 chk("r9_acc", 32'(IssueAccept), 32'd1);
        cycle("wbiss9");
        drive(0, 0, 0, 0, 0, 9, 9);
        #1 chk("r9_data", ReadData1, 32'h11);
        chk("r9_rdy", 32'(Ready1), 32'd0);
        chk("r9_cnt", 32'(PendingCount), 32'd1);
        cycle("rd9");
        drive(1, 9, 32'h22, 0, 0, 9, 0);
        cycle("clr9");

        // Fill the scoreboard, then drain it
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 1, 5'(r), 5'(r), 5'(r - 1));
            cycle("fill");
        end
        chk("full_cnt", 32'(PendingCount), 32'd31);
        for (int r = 1; r < 32; r++) begin
            drive(1, 5'(r), $urandom, 0, 0, 5'(r), 5'(32 - r));
            cycle("drain");
        end
        chk("drain_cnt", 32'(PendingCount), 32'd0);
        chk("drain_busy", 32'(Busy), 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            cycle("rand");
        end

        // Asynchronous reset mid-cycle, held across an edge with a write
        drive(1, 12, 32'hCAFEF00D, 1, 3, 0, 0);
        cycle("pre_rst");
        drive(0, 0, 0, 0, 0, 12, 3);
        #2 reset = 1'b1;
        #1 chk("arst_data", ReadData1, 32'h0);
        chk("arst_rdy", 32'(Ready2), 32'd1);
        chk("arst_cnt", 32'(PendingCount), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        drive(1, 12, 32'h12341234, 1, 4, 13, 0);
        @(posedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        m_clear();
        drive(0, 0, 0, 0, 0, 12, 4);
        #1 chk("held_rst_data", ReadData1, 32'h0);
        chk("held_rst_rdy", 32'(Ready2), 32'd1);
        cycle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
